alu_arbiter: RTL and testbench

- Shares the single combinational RV32I ALU between two requesters: port 0 is the execute stage, port 1 is the address-generation/CSR helper.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Drives the ALU operand/select inputs for the granted request and captures the ALU result and flags into a one-entry response register.
- The response register is tagged with the requester ID and drained under a valid/ready handshake.

---
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational RV32I ALU between two requesters (port 0:
//   execute stage, port 1: address-generation/CSR helper). Round-robin
//   arbitration picks one request per cycle; the ALU outputs are captured
//   into a one-entry response register tagged with the requester ID.
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   req{0,1}_valid/_ready        request handshake per requester
//   req{0,1}_a/_b/_sel           operands and ALU op for each requester
//   alu_a/alu_b/alu_sel          operands/op driven to the shared ALU
//   alu_result/zero/lt_s/lt_u    ALU outputs
//   rsp_valid/rsp_ready          response handshake
//   rsp_id                       requester that issued the held response
//   rsp_result/zero/lt_s/lt_u    registered ALU outputs
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_lt_s,
    input  logic             alu_lt_u,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_lt_s,
    output logic             rsp_lt_u
);

    logic             rsp_valid_q,  rsp_valid_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q,   rsp_zero_d;
    logic             rsp_lt_s_q,   rsp_lt_s_d;
    logic             rsp_lt_u_q,   rsp_lt_u_d;
    logic             last_grant_q, last_grant_d;

    logic can_accept;
    logic grant_vld;
    logic grant_id;
    logic issue;

    always_comb begin
        // Slot is free, or its current occupant leaves this cycle.
        can_accept = !rsp_valid_q || rsp_ready;

        grant_vld = req0_valid || req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end

        // Nothing is issued while reset is asserted.
        issue      = rst_n && grant_vld && can_accept;
        req0_ready = issue && !grant_id;
        req1_ready = issue && grant_id;

        // ALU inputs follow the winner even when stalled; zero when idle.
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = '0;
        if (grant_vld) begin
            alu_a   = grant_id ? req1_a   : req0_a;
            alu_b   = grant_id ? req1_b   : req0_b;
            alu_sel = grant_id ? req1_sel : req0_sel;
        end

        rsp_valid_d  = issue || (rsp_valid_q && !rsp_ready);
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_lt_s_d   = rsp_lt_s_q;
        rsp_lt_u_d   = rsp_lt_u_q;
        last_grant_d = last_grant_q;
        if (issue) begin
            rsp_id_d     = grant_id;
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            rsp_lt_s_d   = alu_lt_s;
            rsp_lt_u_d   = alu_lt_u;
            last_grant_d = grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_lt_s_q   <= 1'b0;
            rsp_lt_u_q   <= 1'b0;
            // Requester 0 wins the first contention after reset.
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_lt_s_q   <= rsp_lt_s_d;
            rsp_lt_u_q   <= rsp_lt_u_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_lt_s   = rsp_lt_s_q;
    assign rsp_lt_u   = rsp_lt_u_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Bench for alu_arbiter. A behavioural RV32I ALU stub answers the DUT's
//   ALU port; a transaction-level model of the arbiter predicts ready,
//   ALU drive and the response register every cycle.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_sel, req1_sel;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_sel;
    logic        alu_zero, alu_lt_s, alu_lt_u;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_lt_s, rsp_lt_u;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Model state
    bit          m_vld, m_id, m_last, m_z, m_ls, m_lu, m_rst;
    logic [31:0] m_res;
    bit          e_r0, e_r1;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .SEL_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_lt_s(alu_lt_s), .alu_lt_u(alu_lt_u),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_lt_s(rsp_lt_s), .rsp_lt_u(rsp_lt_u)
    );

    // RV32I ALU, sel = {funct7[5], funct3}; undefined codes give 0.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] sel);
        case (sel)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return {31'd0, $signed(a) < $signed(b)};
            4'b0011: return {31'd0, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return $unsigned($signed(a) >>> b[4:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_a, alu_b, alu_sel);
        alu_zero   = (alu_result == 32'd0);
        alu_lt_s   = ($signed(alu_a) < $signed(alu_b));
        alu_lt_u   = (alu_a < alu_b);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven (at negedge).
    task automatic step();
        bit          can, gv, g;
        logic [31:0] ea, eb;
        logic [3:0]  es;
        #1;
        can  = !m_vld || rsp_ready;
        gv   = req0_valid || req1_valid;
        g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
        e_r0 = rst_n && gv && !g && can;
        e_r1 = rst_n && gv && g && can;
        ea   = !gv ? 32'd0 : (g ? req1_a   : req0_a);
        eb   = !gv ? 32'd0 : (g ? req1_b   : req0_b);
        es   = !gv ? 4'd0  : (g ? req1_sel : req0_sel);
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_sel", {28'd0, alu_sel}, {28'd0, es});
        @(posedge clk);
        m_rst = !rst_n;
        if (!rst_n) begin
            m_vld = 0; m_id = 0; m_res = 0; m_z = 0; m_ls = 0; m_lu = 0; m_last = 1;
        end else if (e_r0 || e_r1) begin
            m_res  = alu_fn(ea, eb, es);
            m_z    = (m_res == 0);
            m_ls   = ($signed(ea) < $signed(eb));
            m_lu   = (ea < eb);
            m_id   = g;
            m_vld  = 1;
            m_last = g;
        end else if (rsp_ready) begin
            m_vld = 0;
        end
        #1;
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_vld});
        if (m_vld || m_rst) begin
            chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_flags", {29'd0, rsp_zero, rsp_lt_s, rsp_lt_u}, {29'd0, m_z, m_ls, m_lu});
        end
        @(negedge clk);
    endtask

    task automatic set0(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        req0_valid = v; req0_a = a; req0_b = b; req0_sel = s;
    endtask

    task automatic set1(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        req1_valid = v; req1_a = a; req1_b = b; req1_sel = s;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [31:0] held;
    bit          held_id;
    int unsigned grants0, grants1;

    initial begin
        m_vld = 0; m_id = 0; m_last = 1; m_res = 0; m_z = 0; m_ls = 0; m_lu = 0; m_rst = 0;
        rsp_ready = 1'b1;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        step();
        rst_n = 1'b1;

        // req0 ADD 5+3
        set0(1, 5, 3, 4'b0000);
        step();
        chk("t1_ready_seen", {31'd0, e_r0}, 32'd1);
        chk("t1_result", rsp_result, 32'd8);
        chk("t1_id", {31'd0, rsp_id}, 32'd0);
        set0(0, 0, 0, 0);
        step();

        // Contention straight after reset: req0 SUB 7-7, req1 SLTU 1<2
        do_reset();
        set0(1, 7, 7, 4'b1000);
        set1(1, 1, 2, 4'b0011);
        step();
        chk("t2_first_id", {31'd0, rsp_id}, 32'd0);
        chk("t2_first_zero", {31'd0, rsp_zero}, 32'd1);
        set0(0, 0, 0, 0);
        step();
        chk("t2_second_id", {31'd0, rsp_id}, 32'd1);
        chk("t2_second_res", rsp_result, 32'd1);
        chk("t2_second_ltu", {31'd0, rsp_lt_u}, 32'd1);
        set1(0, 0, 0, 0);

        // Both held valid for 6 ops: strict alternation, no bubble
        do_reset();
        grants0 = 0; grants1 = 0;
        set0(1, $urandom, $urandom, 4'b0000);
        set1(1, $urandom, $urandom, 4'b0100);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t3_alt_id", {31'd0, rsp_id}, i % 2);
            chk("t3_no_bubble", {31'd0, rsp_valid}, 32'd1);
            if (e_r0) begin grants0++; set0(1, $urandom, $urandom, 4'b0000); end
            if (e_r1) begin grants1++; set1(1, $urandom, $urandom, 4'b0100); end
        end
        chk("t3_grants0", grants0, 32'd3);
        chk("t3_grants1", grants1, 32'd3);
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        step();

        // Backpressure: response held 3 cycles, then drain + issue together
        set0(1, 32'h10, 32'h20, 4'b0110);
        rsp_ready = 1'b1;
        step();
        set0(0, 0, 0, 0);
        held = rsp_result; held_id = rsp_id;
        rsp_ready = 1'b0;
        set1(1, 32'hFFFF_FFFF, 32'd1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_stall_ready", {31'd0, req1_ready}, 32'd0);
            chk("t4_hold_res", rsp_result, held);
            chk("t4_hold_id", {31'd0, rsp_id}, {31'd0, held_id});
        end
        rsp_ready = 1'b1;
        step();
        chk("t4_overwrite_vld", {31'd0, rsp_valid}, 32'd1);
        chk("t4_overwrite_res", rsp_result, 32'd0);
        chk("t4_overwrite_id", {31'd0, rsp_id}, 32'd1);

        // Reset while a response is held and both requesters are valid
        rsp_ready = 1'b0;
        set0(1, 3, 4, 4'b0111);
        set1(1, 9, 2, 4'b0001);
        rst_n = 1'b0;
        step();
        chk("t5_rst_vld", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        step();
        chk("t5_first_grant", {31'd0, rsp_id}, 32'd0);
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        step();

        // req1 SRA alone, then idle cycles
        set1(1, 32'h8000_0000, 32'd4, 4'b1101);
        step();
        chk("t6_sra_res", rsp_result, 32'hF800_0000);
        chk("t6_sra_lts", {31'd0, rsp_lt_s}, 32'd1);
        chk("t6_sra_id", {31'd0, rsp_id}, 32'd1);
        set1(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t6_idle_alu", alu_a | alu_b | {28'd0, alu_sel}, 32'd0);
        end

        // Randomised traffic, requesters obey valid/ready protocol
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                set0(1, a, b, 4'($urandom_range(0, 15)));
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                set1(1, a, b, 4'($urandom_range(0, 15)));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 63) != 0);
            step();
            rst_n = 1'b1;
            if (e_r0) set0(0, 0, 0, 0);
            if (e_r1) set1(0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
